// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable FIFO family:
// read-mode encodings and the occupancy-counter width helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // The counter must reach RAM_DEPTH itself, so it needs one bit
    // more than the address.
    function automatic int fifo_cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Ports: clk, reset (clears read register), we/waddr/wdata, re/raddr/rdata.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter     TYPE       = "distributed"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    (* ram_style = TYPE *)
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its word unless a new read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_prog_fwft.sv
// Synchronous FIFO with standard or fall-through read, programmable
// almost-full/empty, occupancy count, flush and sticky error flags.
// Ports: clk, reset, flush, clear_err; s_write_req/data/ready;
//        s_read_req/ready/data/valid; count, full, empty,
//        almost_full, almost_empty, overflow, underflow.
module fifo_prog_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = RAM_DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter     TYPE       = "distributed"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic                  s_write_req,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    output logic                  s_write_ready,
    input  logic                  s_read_req,
    output logic                  s_read_ready,
    output logic [DATA_WIDTH-1:0] s_read_data,
    output logic                  s_read_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = fifo_cnt_w(ADDR_WIDTH);
    localparam bit IS_FWFT = (FWFT == FIFO_FWFT);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH &&
          AF_THRESH <= RAM_DEPTH)) begin : g_bad_thresh
        $error("fifo_prog_fwft: need 0 < AE < AF <= RAM_DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CW-1:0]         count_r, count_nxt, ram_cnt;
    logic full_r, empty_r, af_r, ae_r;
    logic rvalid_r, rvalid_nxt;
    logic ovf_r, unf_r, ovf_set, unf_set;
    logic wr_acc, rd_acc, ram_re;

    assign s_write_ready = !full_r;
    // In fall-through mode the RAM read register is the head word.
    assign s_read_ready  = IS_FWFT ? rvalid_r : !empty_r;
    assign s_read_valid  = rvalid_r;

    assign wr_acc  = s_write_req && !full_r && !flush;
    assign rd_acc  = s_read_req && s_read_ready && !flush;
    assign ovf_set = s_write_req && full_r && !flush;
    assign unf_set = s_read_req && !s_read_ready && !flush;

    // Words still inside the RAM, excluding a valid head.
    assign ram_cnt = IS_FWFT ? count_r - CW'(rvalid_r) : count_r;

    always_comb begin
        ram_re     = 1'b0;
        rvalid_nxt = 1'b0;
        if (IS_FWFT) begin
            // Refill the head whenever it is empty or being popped.
            ram_re     = !flush && (!rvalid_r || rd_acc) &&
                         (ram_cnt != '0);
            rvalid_nxt = !flush && (ram_re || (rvalid_r && !rd_acc));
        end else begin
            ram_re     = rd_acc;
            rvalid_nxt = rd_acc;
        end
    end

    always_comb begin
        count_nxt = count_r;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count_r + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_r - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
            rvalid_r <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + ADDR_WIDTH'(1);
                if (ram_re) rptr <= rptr + ADDR_WIDTH'(1);
            end
            count_r  <= count_nxt;
            full_r   <= (count_nxt == DEPTH_C);
            empty_r  <= (count_nxt == '0);
            af_r     <= (count_nxt >= AF_C);
            ae_r     <= (count_nxt <= AE_C);
            rvalid_r <= rvalid_nxt;
            ovf_r    <= ovf_set || (ovf_r && !clear_err);
            unf_r    <= unf_set || (unf_r && !clear_err);
        end
    end

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TYPE       (TYPE)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (s_write_data),
        .re    (ram_re),
        .raddr (rptr),
        .rdata (s_read_data)
    );

endmodule
